xkbd_ctrl: RTL
==============

XKBD_CTRL -- requirements
Module: xkbd_ctrl

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 4, event FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL provide parameter TIMEOUT, default 100000, clk cycles a prefix state may wait for its next byte.
REQ-003 The block SHALL have port clk input 1, single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst input 1, synchronous active-high reset.
REQ-005 The block SHALL have port byte_valid input 1, one-cycle strobe from PS/2 byte receiver.
REQ-006 The block SHALL have port byte_in input 8, received scancode byte, valid with byte_valid.
REQ-007 The block SHALL have port sel input 1, data-bus select for this block.
REQ-008 The block SHALL have port we input 1, data-bus write enable.
REQ-009 The block SHALL have port addr input 1, register select: 0 = EVENT, 1 = STATUS.
REQ-010 The block SHALL have port data_in input 32, data-bus write data.
REQ-011 The block SHALL have port data_out output 32, data-bus read data.
REQ-012 The block SHALL have port event_pending output 1, high while FIFO is non-empty.

Function
REQ-013 Decoder FSM states SHALL be IDLE, BRK, EXT, EXT_BRK; bytes processed only in cycles with byte_valid=1.
REQ-014 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; other -> push {brk=0,ext=0,code}, stay IDLE.
REQ-015 EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT; other -> push {0,1,code}, -> IDLE.
REQ-016 BRK: 0xE0 -> EXT_BRK; 0xF0 -> stay BRK; other -> push {1,0,code}, -> IDLE.
REQ-017 EXT_BRK: 0xE0/0xF0 -> stay; other -> push {1,1,code}, -> IDLE.
REQ-018 Timeout counter SHALL clear on every byte_valid and whenever FSM is IDLE, increment otherwise, and force FSM to IDLE with no push when it reaches TIMEOUT-1.
REQ-019 Event word SHALL be 10 bits: [9]=brk, [8]=ext, [7:0]=code.
REQ-020 Push when FIFO full (and no same-cycle pop) SHALL drop the event and set sticky overflow.
REQ-021 EVENT read (sel=1, we=0, addr=0): data_out = {22'b0, head event} combinationally in the same cycle; FIFO pops at that cycle's clock edge; if empty data_out = 0 and no pop.
REQ-022 STATUS read (sel=1, we=0, addr=1): data_out = {26'b0, overflow, full, count[3:0]} combinationally; no side effects.
REQ-023 data_out SHALL be 0 whenever sel=0.
REQ-024 STATUS write (sel=1, we=1, addr=1): data_in[0]=1 flushes FIFO (count=0) and clears overflow; data_in[5]=1 clears overflow only; writes to addr 0 ignored.
REQ-025 Simultaneous push and pop: both take effect, count unchanged; when full, push accepted with no overflow.
REQ-026 Simultaneous push and pop on empty FIFO: read returns 0, push stored, count becomes 1.
REQ-027 Flush and push in same cycle: flush wins, event discarded, count=0.
REQ-028 Overflow set and clear in same cycle: clear wins.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-030 event_pending SHALL be registered-state derived (count != 0), no combinational path from bus inputs.

Reset
REQ-031 On rst=1 at a clock edge: FSM=IDLE, timeout counter=0, pointers=0, count=0, overflow=0; event_pending=0 next cycle; rst SHALL override all same-cycle bytes and bus accesses.
REQ-032 Reset mid-sequence (e.g. after 0xE0) SHALL leave FSM IDLE; next byte 0x1C decodes as plain make.

Verification
REQ-033 Bytes 0x1C; 0xF0,0x1C -> two events; EVENT reads return 0x01C then 0x21C; then STATUS = 0x00.
REQ-034 Bytes 0xE0,0x75; 0xE0,0xF0,0x75 -> EVENT reads return 0x175 then 0x375.
REQ-035 Six make codes 0x01..0x06 with no reads (DEPTH=4) -> STATUS = 0x34 (overflow, full, count 4); reads return 0x001..0x004; write 0x20 to STATUS -> STATUS = 0x00.
REQ-036 Byte 0xF0 then no byte for TIMEOUT cycles, then 0x1C -> single event 0x01C; with TIMEOUT=8 verify FSM back in IDLE after exactly 8 idle cycles.
REQ-037 FIFO full, byte 0x2A pushed in same cycle as EVENT read -> read returns oldest event, no overflow, count stays 4, newest entry 0x02A.
REQ-038 Two events queued, STATUS write 0x01 in same cycle as push of 0x33 -> STATUS = 0x00, event_pending=0, EVENT read returns 0.

Source files
------------

// File: rtl/xkbd_ctrl_if.sv
// Bus-side bundle for xkbd_ctrl: PS/2 byte strobe input plus the register data bus.
interface xkbd_ctrl_if;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        sel;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        event_pending;

  modport master (
    output byte_valid, byte_in, sel, we, addr, data_in,
    input  data_out, event_pending
  );

  modport slave (
    input  byte_valid, byte_in, sel, we, addr, data_in,
    output data_out, event_pending
  );
endinterface

// File: rtl/xkbd_ctrl.sv
// PS/2 set-2 scancode decoder (E0/F0 prefixes with timeout) feeding a small event FIFO
// exposed through EVENT (pop-on-read) and STATUS registers.
module xkbd_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 100000
) (
  input logic         clk,
  input logic         rst,
  xkbd_ctrl_if.slave  bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [7:0] ByteExt = 8'hE0;
  localparam logic [7:0] ByteBrk = 8'hF0;

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tmo_hit;
  logic            push;
  logic [9:0]      push_word;

  logic [9:0]      mem_q [DEPTH];
  logic [PW-1:0]   rptr_q, wptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q;

  logic            rd_evt, rd_stat, wr_stat;
  logic            flush, ovf_clr;
  logic            empty, full;
  logic            pop, push_ok, push_drop;
  logic [3:0]      count4;
  logic            unused_data_in;

  // Decoder

  assign tmo_hit   = (state_q != StIdle) && (tmo_q == TW'(TIMEOUT - 1));
  assign push_word = {(state_q == StBrk) || (state_q == StExtBrk),
                      (state_q == StExt) || (state_q == StExtBrk),
                      bus.byte_in};

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (bus.byte_valid) begin
      unique case (state_q)
        StIdle: begin
          if (bus.byte_in == ByteExt)      state_d = StExt;
          else if (bus.byte_in == ByteBrk) state_d = StBrk;
          else                             push    = 1'b1;
        end
        StExt: begin
          if (bus.byte_in == ByteBrk) state_d = StExtBrk;
          else if (bus.byte_in != ByteExt) begin
            push    = 1'b1;
            state_d = StIdle;
          end
        end
        StBrk: begin
          if (bus.byte_in == ByteExt) state_d = StExtBrk;
          else if (bus.byte_in != ByteBrk) begin
            push    = 1'b1;
            state_d = StIdle;
          end
        end
        StExtBrk: begin
          if ((bus.byte_in != ByteExt) && (bus.byte_in != ByteBrk)) begin
            push    = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (tmo_hit) begin
      // Stale prefix: abandon it without producing an event.
      state_d = StIdle;
    end
  end

  always_comb begin
    if (bus.byte_valid || (state_q == StIdle) || tmo_hit) tmo_d = '0;
    else                                                  tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  // Register bus decode and FIFO

  assign rd_evt  = bus.sel && !bus.we && !bus.addr;
  assign rd_stat = bus.sel && !bus.we &&  bus.addr;
  assign wr_stat = bus.sel &&  bus.we &&  bus.addr;
  assign flush   = wr_stat && bus.data_in[0];
  assign ovf_clr = wr_stat && (bus.data_in[0] || bus.data_in[5]);

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = rd_evt && !empty;
  assign push_ok   = push && (!full || pop) && !flush;
  assign push_drop = push && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= push_word;
  end

  // Clear beats a same-cycle overflow.
  always_ff @(posedge clk) begin
    if (rst)            ovf_q <= 1'b0;
    else if (ovf_clr)   ovf_q <= 1'b0;
    else if (push_drop) ovf_q <= 1'b1;
  end

  assign count4 = 4'(count_q);

  always_comb begin
    bus.data_out = '0;
    if (rd_stat)               bus.data_out = {26'b0, ovf_q, full, count4};
    else if (rd_evt && !empty) bus.data_out = {22'b0, mem_q[rptr_q]};
  end

  assign bus.event_pending = !empty;

  assign unused_data_in = ^{bus.data_in[31:6], bus.data_in[4:1]};

endmodule
